aes_inv_round_core: RTL and testbench
=====================================

AES_INV_ROUND_CORE -- requirements
Module: aes_inv_round_core

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 Port list SHALL be, clock and reset first:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to decrypt; sampled only in IDLE
- key_in  input  128  AES-128 cipher key (round key 0)
- data_in  input  128  ciphertext block
- busy  output  1  high from the start-accept edge until the done edge
- done  output  1  single-cycle completion pulse
- data_out  output  128  plaintext; valid while done=1 and held afterwards
REQ-003 Byte order SHALL follow FIPS-197: bits [127:120] = byte 0; bytes map column-major into the state (byte 4c+r = row r, column c).

Function
REQ-004 The block SHALL perform iterative AES-128 decryption, one round per cycle, with internal registers state_r[127:0], key_r[127:0] and rcnt[3:0].
REQ-005 FSM states SHALL be IDLE, KEYEXP, ROUND and FINAL.
REQ-006 IDLE with start=1 SHALL, at that edge, latch key_r<=key_in and state_r<=data_in, set rcnt<=1 and busy<=1, and go to KEYEXP.
REQ-007 KEYEXP SHALL run 10 cycles.
- Each cycle: key_r <= forward key-schedule step using Rcon(rcnt) (01,02,04,08,10,20,40,80,1b,36); rcnt increments.
- On the 10th cycle: state_r <= state_r ^ next key (round key 10 AddRoundKey), rcnt<=9, go to ROUND.
REQ-008 ROUND SHALL run 9 cycles. Each cycle:
- prev = inverse key-schedule step of key_r using Rcon(rcnt+1), giving round key rcnt.
- state_r <= InvMixColumns(InvSubBytes(InvShiftRows(state_r)) ^ prev).
- key_r <= prev; rcnt decrements.
- After rcnt=1, go to FINAL.
REQ-009 Inverse key step SHALL be w0=k0^SubWord(RotWord(k3_new))^Rcon; w1=k1^k0; w2=k2^k1; w3=k3^k2, where k3_new=w3.
REQ-010 FINAL SHALL take 1 cycle:
- Compute round key 0 by one more inverse step (Rcon 01).
- data_out <= InvSubBytes(InvShiftRows(state_r)) ^ round key 0.
- done<=1 for exactly one cycle, busy<=0, return to IDLE.
REQ-011 Latency SHALL be fixed: done is high in the cycle following the 20th rising edge after the start-accept edge (10 KEYEXP + 9 ROUND + 1 FINAL).
REQ-012 InvSubBytes SHALL be computed, not tabled: inverse affine transform followed by GF(2^8) multiplicative inverse (polynomial 0x11b, 0 maps to 0). The forward S-box used by the key schedule SHALL be the same inverse followed by the forward affine transform (0x63).
REQ-013 InvMixColumns SHALL multiply each column by the matrix {0e,0b,0d,09} over GF(2^8) mod 0x11b.
REQ-014 start while busy=1 SHALL be ignored; key_in and data_in SHALL NOT be sampled except at the accept edge.
REQ-015 start held high continuously SHALL start a new operation on the edge after done, that is, when the FSM is back in IDLE, giving a throughput of one block per 21 cycles.
REQ-016 data_out SHALL change only at the FINAL edge and SHALL hold until the next FINAL.

Reset
REQ-017 While rst_n=0, asynchronously: FSM=IDLE, busy=0, done=0, data_out=0, state_r=0, key_r=0, rcnt=0.
REQ-018 Assertion of rst_n mid-operation SHALL abort the operation with no done pulse. The first start after release SHALL behave as from power-up.
REQ-019 start SHALL NOT be accepted on the edge at which rst_n deasserts if rst_n is synchronized low at that edge. The block SHALL accept start only on edges where rst_n=1.

Verification
REQ-020 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff and done exactly 20 edges after accept. Internally, key_r after KEYEXP = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-021 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> data_out 3243f6a8885a308d313198a2e0370734.
REQ-022 Pulse start again at cycle 5 of an operation with a different key and data -> the first result is unchanged, no second done, and busy stays high continuously.
REQ-023 Assert rst_n low at cycle 12 of C.1, release it, then run B -> no done for C.1, all outputs 0 during reset, B correct with latency 20.
REQ-024 start held high for 3 back-to-back operations (C.1, B, C.1) -> done pulses 21 cycles apart, each data_out correct and held between pulses.
REQ-025 Random key/plaintext pairs encrypted by the existing encryption round chain and fed back -> data_out equals the original plaintext for 1000 vectors.

Source files
------------

// File: rtl/aes_inv_round_core.sv
// Iterative AES-128 decryption core: forward key expansion to round key 10, then
// one inverse round per cycle with an on-the-fly inverse key schedule.
module aes_inv_round_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out
);

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, FINAL} state_t;

    state_t       st, st_nx;
    logic [127:0] state_r, key_r;
    logic [3:0]   rcnt;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero naturally maps to zero
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte 4c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r columns
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [31:0]  sw_in, sw_out;
    logic [31:0]  fw0, fw1, fw2, fw3, iw0, iw1, iw2, iw3;
    logic [127:0] fwd_key, inv_key, shift_sub;

    // One SubWord serves both directions: forward uses k3, inverse uses k3^k2
    always_comb begin
        sw_in     = (st == KEYEXP) ? key_r[31:0] : (key_r[31:0] ^ key_r[63:32]);
        sw_out    = sub_word({sw_in[23:0], sw_in[31:24]});
        fw0       = key_r[127:96] ^ sw_out ^ {rcon(rcnt), 24'h0};
        fw1       = key_r[95:64] ^ fw0;
        fw2       = key_r[63:32] ^ fw1;
        fw3       = key_r[31:0] ^ fw2;
        iw1       = key_r[95:64] ^ key_r[127:96];
        iw2       = key_r[63:32] ^ key_r[95:64];
        iw3       = key_r[31:0] ^ key_r[63:32];
        iw0       = key_r[127:96] ^ sw_out ^ {rcon(rcnt + 4'd1), 24'h0};
        fwd_key   = {fw0, fw1, fw2, fw3};
        inv_key   = {iw0, iw1, iw2, iw3};
        shift_sub = inv_shift_sub(state_r);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (start) st_nx = KEYEXP;
            KEYEXP:  if (rcnt == 4'd10) st_nx = ROUND;
            ROUND:   if (rcnt == 4'd1) st_nx = FINAL;
            FINAL:   st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            state_r  <= '0;
            key_r    <= '0;
            rcnt     <= '0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        key_r   <= key_in;
                        state_r <= data_in;
                        rcnt    <= 4'd1;
                        busy    <= 1'b1;
                    end
                end
                KEYEXP: begin
                    key_r <= fwd_key;
                    if (rcnt == 4'd10) begin
                        state_r <= state_r ^ fwd_key;
                        rcnt    <= 4'd9;
                    end else begin
                        rcnt <= rcnt + 4'd1;
                    end
                end
                ROUND: begin
                    state_r <= inv_mix_columns(shift_sub ^ inv_key);
                    key_r   <= inv_key;
                    rcnt    <= rcnt - 4'd1;
                end
                FINAL: begin
                    data_out <= shift_sub ^ inv_key;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_core.sv
// Directed and model-driven bench for aes_inv_round_core, using FIPS-197 vectors
// and an independent table-based forward AES model for random round trips.
module tb_aes_inv_round_core;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk, rst_n, start, busy, done;
    logic [127:0] key_in, data_in, data_out;
    int           errors = 0;
    int           checks = 0;
    logic [7:0]   sb [256];

    aes_inv_round_core dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .data_in(data_in), .busy(busy), .done(done), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward S-box built by walking generator 3 and its inverse in parallel
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] tb_xt(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [127:0] rk, s, t, u;
        logic [31:0]  w0, w1, w2, w3, sw;
        logic [7:0]   rc, a0, a1, a2, a3;
        rk = key;
        s  = pt ^ rk;
        rc = 8'h01;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sb[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[127-8*(4*c+r) -: 8] = t[127-8*(4*((c+r)%4)+r) -: 8];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = u[127-32*c -: 8];
                    a1 = u[119-32*c -: 8];
                    a2 = u[111-32*c -: 8];
                    a3 = u[103-32*c -: 8];
                    u[127-32*c -: 8] = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
                    u[119-32*c -: 8] = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
                    u[111-32*c -: 8] = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
                    u[103-32*c -: 8] = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
                end
            end
            sw = {sb[rk[23:16]], sb[rk[15:8]], sb[rk[7:0]], sb[rk[31:24]]};
            w0 = rk[127:96] ^ sw ^ {rc, 24'h0};
            w1 = rk[95:64] ^ w0;
            w2 = rk[63:32] ^ w1;
            w3 = rk[31:0] ^ w2;
            rk = {w0, w1, w2, w3};
            rc = tb_xt(rc);
            s  = u ^ rk;
        end
        return s;
    endfunction

    // Pulses start for one accept edge, then waits (bounded) for done
    task automatic do_op(input logic [127:0] k, input logic [127:0] d,
                         output logic [127:0] res, output int lat);
        key_in  = k;
        data_in = d;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = data_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; key_in = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1; start = 1'b1; key_in = C1_KEY; data_in = C1_CT;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (data_out !== '0) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 0", data_out); end
        checks++; if (dut.state_r !== '0) begin errors++; $display("[TB] FAIL reset_state_r: got %h expected 0", dut.state_r); end
        checks++; if (dut.key_r !== '0) begin errors++; $display("[TB] FAIL reset_key_r: got %h expected 0", dut.key_r); end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_fips_c1();
        int lat;
        key_in = C1_KEY; data_in = C1_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; key_in = B_KEY; data_in = B_CT;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL c1_busy_at_accept: got %b expected 1", busy); end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (dut.key_r !== C1_RK10) begin errors++; $display("[TB] FAIL c1_round_key10: got %h expected %h", dut.key_r, C1_RK10); end
        lat = 10;
        while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 20) begin errors++; $display("[TB] FAIL c1_latency: got %0d expected 20", lat); end
        checks++; if (data_out !== C1_PT) begin errors++; $display("[TB] FAIL c1_data_out: got %h expected %h", data_out, C1_PT); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL c1_busy_at_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL c1_done_width: got %b expected 0", done); end
        checks++; if (data_out !== C1_PT) begin errors++; $display("[TB] FAIL c1_data_hold: got %h expected %h", data_out, C1_PT); end
    endtask

    task automatic test_fips_b();
        logic [127:0] res;
        int lat;
        do_op(B_KEY, B_CT, res, lat);
        checks++; if (lat != 20) begin errors++; $display("[TB] FAIL b_latency: got %0d expected 20", lat); end
        checks++; if (res !== B_PT) begin errors++; $display("[TB] FAIL b_data_out: got %h expected %h", res, B_PT); end
    endtask

    task automatic test_start_while_busy();
        int n;
        bit busy_drop, extra_done;
        busy_drop = 0; extra_done = 0;
        key_in = C1_KEY; data_in = C1_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 4) begin start = 1'b1; key_in = B_KEY; data_in = B_CT; end
            if (n == 5) start = 1'b0;
            if (done !== 1'b1 && busy !== 1'b1) busy_drop = 1;
        end
        checks++; if (n != 20) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 20", n); end
        checks++; if (data_out !== C1_PT) begin errors++; $display("[TB] FAIL busy_start_data: got %h expected %h", data_out, C1_PT); end
        checks++; if (busy_drop) begin errors++; $display("[TB] FAIL busy_start_continuous: got drop=1 expected drop=0"); end
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra_done = 1;
        end
        checks++; if (extra_done) begin errors++; $display("[TB] FAIL busy_start_second_done: got 1 expected 0"); end
    endtask

    task automatic test_reset_mid_op();
        logic [127:0] res;
        int lat;
        bit early_done;
        early_done = 0;
        key_in = C1_KEY; data_in = C1_CT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) early_done = 1;
        end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (data_out !== '0) begin errors++; $display("[TB] FAIL midreset_data_out: got %h expected 0", data_out); end
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) early_done = 1;
        end
        rst_n = 1'b1;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1) early_done = 1;
        end
        checks++; if (early_done) begin errors++; $display("[TB] FAIL midreset_abort: got done=1 expected no done"); end
        do_op(B_KEY, B_CT, res, lat);
        checks++; if (lat != 20) begin errors++; $display("[TB] FAIL midreset_b_latency: got %0d expected 20", lat); end
        checks++; if (res !== B_PT) begin errors++; $display("[TB] FAIL midreset_b_data: got %h expected %h", res, B_PT); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_pt [3];
        logic [127:0] exp_hold;
        int pulse_at [3];
        int n, npulse;
        bit holding, bad_hold;
        exp_pt = '{C1_PT, B_PT, C1_PT};
        pulse_at = '{0, 0, 0};
        exp_hold = '0; npulse = 0; holding = 0; bad_hold = 0;
        key_in = C1_KEY; data_in = C1_CT; start = 1'b1;
        @(posedge clk); #1;
        key_in = B_KEY; data_in = B_CT; n = 0;
        while (n < 70) begin
            @(posedge clk); #1;
            n++;
            if (n == 21) begin key_in = C1_KEY; data_in = C1_CT; end
            if (n == 42) start = 1'b0;
            if (done === 1'b1) begin
                if (npulse < 3) begin
                    pulse_at[npulse] = n;
                    checks++;
                    if (data_out !== exp_pt[npulse]) begin
                        errors++;
                        $display("[TB] FAIL b2b_data%0d: got %h expected %h", npulse, data_out, exp_pt[npulse]);
                    end
                    exp_hold = exp_pt[npulse];
                end
                npulse++;
                holding = 1;
            end else if (holding && data_out !== exp_hold) begin
                bad_hold = 1;
            end
        end
        checks++; if (npulse != 3) begin errors++; $display("[TB] FAIL b2b_pulse_count: got %0d expected 3", npulse); end
        checks++; if (pulse_at[0] != 20) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected 20", pulse_at[0]); end
        checks++; if (pulse_at[1] - pulse_at[0] != 21) begin errors++; $display("[TB] FAIL b2b_gap1: got %0d expected 21", pulse_at[1] - pulse_at[0]); end
        checks++; if (pulse_at[2] - pulse_at[1] != 21) begin errors++; $display("[TB] FAIL b2b_gap2: got %0d expected 21", pulse_at[2] - pulse_at[1]); end
        checks++; if (bad_hold) begin errors++; $display("[TB] FAIL b2b_hold: got changed data_out expected held value"); end
    endtask

    task automatic test_random_roundtrip();
        logic [127:0] k, pt, ct, res;
        int lat;
        for (int v = 0; v < 1000; v++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = model_encrypt(k, pt);
            do_op(k, ct, res, lat);
            checks++;
            if (res !== pt || lat != 20) begin
                errors++;
                $display("[TB] FAIL random%0d: got %h lat %0d expected %h lat 20", v, res, lat, pt);
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
        test_random_roundtrip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
